// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache flush engine.
// Holds the FSM state encoding and the write-back address composition.
package dcache_pkg;
   localparam int TAG_W     = 25;
   localparam int LINE_W    = 256;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;
   localparam int IDX_W     = 4;
   localparam int WAY_W     = 1;
   localparam int CNT_W     = 6;
   localparam int ADDR_W    = 32;
   localparam logic [CNT_W-1:0] MAX_LINES = CNT_W'(32);

   typedef enum logic [2:0] {IDLE, SCAN, WB, CLEAR, DONE} flush_state_e;

   // Line address = {tag, set index, 32-byte line offset}
   function automatic logic [ADDR_W-1:0] compose_addr(input logic [DIRTY_BIT-1:0] tag,
                                                      input logic [IDX_W-1:0]     idx);
      return {tag, idx, 5'b0};
   endfunction
endpackage

// File: rtl/dcache_flush_engine_if.sv
// Flush-engine bus: CPU flush handshake, cache SRAM access and data-memory write port.
// Macro DCACHE_FLUSH_INVALIDATE_EN adds the sram_inv_o valid-clear strobe.
interface dcache_flush_if;
   import dcache_pkg::*;
   logic                flush_req_i;
   logic                flush_busy_o;
   logic                flush_done_o;
   logic [CNT_W-1:0]    lines_written_o;
   logic [IDX_W-1:0]    sram_idx_o;
   logic [WAY_W-1:0]    sram_way_o;
   logic [TAG_W-1:0]    sram_tag_i;
   logic [LINE_W-1:0]   sram_data_i;
   logic                sram_clr_dirty_o;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
   logic                sram_inv_o;
`endif
   logic                mem_enable_o;
   logic                mem_write_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [LINE_W-1:0]   mem_data_o;
   logic                mem_ack_i;

   modport master (
`ifdef DCACHE_FLUSH_INVALIDATE_EN
      output sram_inv_o,
`endif
      input  flush_req_i, sram_tag_i, sram_data_i, mem_ack_i,
      output flush_busy_o, flush_done_o, lines_written_o, sram_idx_o, sram_way_o,
             sram_clr_dirty_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport slave (
`ifdef DCACHE_FLUSH_INVALIDATE_EN
      input  sram_inv_o,
`endif
      output flush_req_i, sram_tag_i, sram_data_i, mem_ack_i,
      input  flush_busy_o, flush_done_o, lines_written_o, sram_idx_o, sram_way_o,
             sram_clr_dirty_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/dcache_flush_engine_flush_ptr.sv
// Entry pointer for the flush walk: sets 0..NUM_SETS-1 of way 0, then the next way.
module flush_ptr #(
   parameter int NUM_SETS = 16,
   parameter int NUM_WAYS = 2,
   parameter int IDX_W    = 4,
   parameter int WAY_W    = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [WAY_W-1:0] way_o,
   output logic             last_o
);
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic             set_last;

   assign set_last = (idx_q == IDX_W'(NUM_SETS-1));
   assign last_o   = set_last && (way_q == WAY_W'(NUM_WAYS-1));
   assign idx_o    = idx_q;
   assign way_o    = way_q;

   always_comb begin
      idx_d = idx_q;
      way_d = way_q;
      if (clr_i) begin
         idx_d = '0;
         way_d = '0;
      end else if (adv_i) begin
         if (set_last) begin
            idx_d = '0;
            way_d = last_o ? '0 : way_q + WAY_W'(1);
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         idx_q <= '0;
         way_q <= '0;
      end else begin
         idx_q <= idx_d;
         way_q <= way_d;
      end
   end
endmodule

// File: rtl/dcache_flush_engine.sv
// Walks every cache entry and writes dirty lines back to memory, clearing their dirty bits.
// Macro DCACHE_FLUSH_INVALIDATE_EN also invalidates every valid entry (cache empty after DONE).
module dcache_flush_engine
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = 16,
   parameter int NUM_WAYS = 2
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   dcache_flush_if.master bus
);
   flush_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic              ptr_clr, ptr_adv, ptr_last;
   logic [IDX_W-1:0]  idx;
   logic [WAY_W-1:0]  way;
   logic              line_valid, line_dirty;

   assign line_valid = bus.sram_tag_i[VALID_BIT];
   assign line_dirty = bus.sram_tag_i[DIRTY_BIT];

   flush_ptr #(
      .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)
   ) u_ptr (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(ptr_clr), .adv_i(ptr_adv),
      .idx_o(idx), .way_o(way), .last_o(ptr_last)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ptr_clr = 1'b0;
      ptr_adv = 1'b0;
      case (state_q)
         IDLE: if (bus.flush_req_i) begin
            ptr_clr = 1'b1;
            cnt_d   = '0;
            state_d = SCAN;
         end
         SCAN: if (line_valid && line_dirty) begin
            // Snapshot the line so the request stays stable while memory stalls
            addr_d  = compose_addr(bus.sram_tag_i[DIRTY_BIT-1:0], idx);
            data_d  = bus.sram_data_i;
            state_d = WB;
         end else begin
            ptr_adv = 1'b1;
            state_d = ptr_last ? DONE : SCAN;
         end
         WB: if (bus.mem_ack_i) state_d = CLEAR;
         CLEAR: begin
            if (cnt_q != MAX_LINES) cnt_d = cnt_q + CNT_W'(1);
            ptr_adv = 1'b1;
            state_d = ptr_last ? DONE : SCAN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode straight from state so reset silences them asynchronously
   assign bus.flush_busy_o     = (state_q != IDLE);
   assign bus.flush_done_o     = (state_q == DONE);
   assign bus.lines_written_o  = cnt_q;
   assign bus.sram_idx_o       = idx;
   assign bus.sram_way_o       = way;
   assign bus.sram_clr_dirty_o = (state_q == CLEAR);
   assign bus.mem_enable_o     = (state_q == WB);
   assign bus.mem_write_o      = (state_q == WB);
   assign bus.mem_addr_o       = addr_q;
   assign bus.mem_data_o       = data_q;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
   assign bus.sram_inv_o = (state_q == CLEAR) ||
                           ((state_q == SCAN) && line_valid && !line_dirty);
`endif
endmodule

// File: tb/tb_dcache_flush_engine.sv
// Self-checking bench for dcache_flush_engine: behavioural cache/memory model, randomized contents.
// Define DCACHE_FLUSH_INVALIDATE_EN to also exercise the invalidate build.
module tb_dcache_flush_engine;
   import dcache_pkg::*;

   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk_i = ~clk_i;

   dcache_flush_if bus();

   dcache_flush_engine #(.NUM_SETS(16), .NUM_WAYS(2)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus.master)
   );

   bit          m_valid [2][16];
   bit          m_dirty [2][16];
   logic [22:0] m_tag   [2][16];
   logic [255:0] m_data [2][16];
   bit          s_valid [2][16];
   bit          s_dirty [2][16];

   logic [31:0]  exp_addr[$], obs_addr[$];
   logic [255:0] exp_data[$], obs_data[$];

   int   r_done_cyc, r_pulses, r_en, r_err, r_busy_err, r_sum;
   bit   r_timeout, r_en_rst, r_busy_rst;
   logic [5:0] r_cnt_rst;
   int   r_abort_w, r_abort_i;

   always_comb begin
      bus.sram_tag_i  = {m_valid[bus.sram_way_o][bus.sram_idx_o],
                         m_dirty[bus.sram_way_o][bus.sram_idx_o],
                         m_tag[bus.sram_way_o][bus.sram_idx_o]};
      bus.sram_data_i = m_data[bus.sram_way_o][bus.sram_idx_o];
   end

   // mode 0: valid/clean mix, 1: all valid+dirty, 2: random mix (incl. dirty-but-invalid)
   task automatic fill(input int mode);
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 16; s++) begin
            m_valid[w][s] = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            m_dirty[w][s] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_tag[w][s]   = 23'($urandom());
            for (int k = 0; k < 8; k++) m_data[w][s][k*32 +: 32] = $urandom();
         end
   endtask

   task automatic snapshot_expect();
      exp_addr.delete();
      exp_data.delete();
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 16; s++) begin
            s_valid[w][s] = m_valid[w][s];
            s_dirty[w][s] = m_dirty[w][s];
            if (m_valid[w][s] && m_dirty[w][s]) begin
               exp_addr.push_back((32'(m_tag[w][s]) << 9) + (32'(s) << 5));
               exp_data.push_back(m_data[w][s]);
            end
         end
   endtask

   // Drives one flush and acts as SRAM write port and memory responder; collects observations.
   // lat_mode 0 = random ack latency per line; abort_line n = reset in WB of n-th write.
   task automatic run_flush(input int lat_mode, input bit hold_req, input bit spurious,
                            input int abort_line);
      int cyc, wbc, line_no, cur_lat, pw, pi_, iw, ii;
      bit pend, pend_inv;
      logic [31:0]  a0;
      logic [255:0] d0;
      obs_addr.delete();
      obs_data.delete();
      r_done_cyc = 0; r_pulses = 0; r_en = 0; r_err = 0; r_busy_err = 0; r_sum = 0;
      r_timeout = 0; r_abort_w = -1; r_abort_i = -1;
      wbc = 0; line_no = 0; cur_lat = 1; pend = 0; pend_inv = 0;
      pw = 0; pi_ = 0; iw = 0; ii = 0; a0 = '0; d0 = '0;
      @(posedge clk_i); #1;
      bus.flush_req_i = 1'b1;
      bus.mem_ack_i   = 1'b0;
      cyc = 1;
      while (1) begin
         @(posedge clk_i); #1;
         cyc++;
         if (!hold_req) bus.flush_req_i = 1'b0;
         if (pend) m_dirty[pw][pi_] = 1'b0;
         if (pend_inv) m_valid[iw][ii] = 1'b0;
         pend = 0; pend_inv = 0;
         if (bus.mem_enable_o) begin
            r_en++; wbc++;
            if (wbc == 1) begin
               line_no++;
               cur_lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 6));
               r_sum += cur_lat + 1;
               a0 = bus.mem_addr_o; d0 = bus.mem_data_o;
               obs_addr.push_back(a0);
               obs_data.push_back(d0);
            end else if (bus.mem_addr_o !== a0 || bus.mem_data_o !== d0) r_err++;
            if (abort_line == line_no && wbc == 2) begin
               r_abort_w = int'(bus.sram_way_o);
               r_abort_i = int'(bus.sram_idx_o);
               rst_n_i = 1'b0;
               #1;
               r_en_rst   = bus.mem_enable_o;
               r_busy_rst = bus.flush_busy_o;
               r_cnt_rst  = bus.lines_written_o;
               break;
            end
            bus.mem_ack_i = (wbc == cur_lat);
         end else begin
            wbc = 0;
            bus.mem_ack_i = spurious && ($urandom_range(0, 2) == 0);
         end
         if (bus.mem_write_o && !bus.mem_enable_o) r_err++;
         if (bus.sram_clr_dirty_o) begin
            pend = 1; pw = int'(bus.sram_way_o); pi_ = int'(bus.sram_idx_o);
         end
`ifdef DCACHE_FLUSH_INVALIDATE_EN
         if (bus.sram_inv_o) begin
            pend_inv = 1; iw = int'(bus.sram_way_o); ii = int'(bus.sram_idx_o);
         end
`endif
         if ((r_done_cyc == 0 || cyc == r_done_cyc) && !bus.flush_busy_o) r_busy_err++;
         if (r_done_cyc != 0 && cyc > r_done_cyc && bus.flush_busy_o) r_busy_err++;
         if (bus.flush_done_o) begin
            r_pulses++;
            if (r_done_cyc == 0) r_done_cyc = cyc;
            bus.flush_req_i = 1'b0;
         end
         if (r_done_cyc != 0 && cyc >= r_done_cyc + 4) break;
         if (cyc > 3000) begin r_timeout = 1; break; end
      end
      bus.mem_ack_i   = 1'b0;
      bus.flush_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      bus.flush_req_i = 1'b1;
      bus.mem_ack_i   = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if (bus.flush_busy_o !== 1'b0 || bus.flush_done_o !== 1'b0) begin
         errors++; $display("FAIL reset_flags busy=%b done=%b expected 0/0", bus.flush_busy_o, bus.flush_done_o); end
      checks++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.sram_clr_dirty_o !== 1'b0) begin
         errors++; $display("FAIL reset_strobes en=%b wr=%b clr=%b expected 0", bus.mem_enable_o, bus.mem_write_o, bus.sram_clr_dirty_o); end
      checks++; if (bus.lines_written_o !== 6'd0 || bus.sram_idx_o !== 4'd0 || bus.sram_way_o !== 1'b0) begin
         errors++; $display("FAIL reset_ptr cnt=%0d idx=%0d way=%0d expected 0", bus.lines_written_o, bus.sram_idx_o, bus.sram_way_o); end
      checks++; if (bus.mem_addr_o !== 32'd0) begin
         errors++; $display("FAIL reset_addr got=%h expected 0", bus.mem_addr_o); end
      bus.flush_req_i = 1'b0;
      bus.mem_ack_i   = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);
   endtask

   task automatic test_all_clean();
      fill(0);
      snapshot_expect();
      run_flush(3, 1'b0, 1'b0, 0);
      checks++; if (r_en !== 0) begin
         errors++; $display("FAIL clean_mem_cycles got=%0d expected 0", r_en); end
      checks++; if (r_done_cyc !== 34 || r_timeout) begin
         errors++; $display("FAIL clean_done_cycle got=%0d expected 34 timeout=%0b", r_done_cyc, r_timeout); end
      checks++; if (bus.lines_written_o !== 6'd0 || r_pulses !== 1) begin
         errors++; $display("FAIL clean_count cnt=%0d pulses=%0d expected 0/1", bus.lines_written_o, r_pulses); end
      checks++; if (r_busy_err !== 0) begin
         errors++; $display("FAIL clean_busy errors=%0d expected 0", r_busy_err); end
   endtask

   task automatic test_single_dirty();
      logic [255:0] d;
      d = {16{16'hECFA}};
      fill(0);
      m_valid[0][3] = 1'b1; m_dirty[0][3] = 1'b1; m_tag[0][3] = 23'h1; m_data[0][3] = d;
      snapshot_expect();
      run_flush(10, 1'b0, 1'b0, 0);
      checks++; if (obs_addr.size() !== 1) begin
         errors++; $display("FAIL single_writes got=%0d expected 1", obs_addr.size()); end
      else begin
         checks++; if (obs_addr[0] !== 32'h0000_0260 || obs_data[0] !== d) begin
            errors++; $display("FAIL single_addr_data addr=%h expected 00000260 data_ok=%0b", obs_addr[0], obs_data[0] === d); end
      end
      checks++; if (m_dirty[0][3] !== 1'b0 || bus.lines_written_o !== 6'd1) begin
         errors++; $display("FAIL single_clear dirty=%b cnt=%0d expected 0/1", m_dirty[0][3], bus.lines_written_o); end
      checks++; if (r_done_cyc !== 45 || r_err !== 0 || r_en !== 10) begin
         errors++; $display("FAIL single_timing done=%0d expected 45 en=%0d expected 10 stab=%0d", r_done_cyc, r_en, r_err); end
   endtask

   task automatic test_all_dirty();
      int bad, left;
      fill(1);
      snapshot_expect();
      run_flush(0, 1'b0, 1'b0, 0);
      bad = 0;
      checks++; if (obs_addr.size() !== 32) begin
         errors++; $display("FAIL alldirty_writes got=%0d expected 32", obs_addr.size()); end
      else begin
         for (int k = 0; k < 32; k++) if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) bad++;
         checks++; if (bad !== 0) begin
            errors++; $display("FAIL alldirty_order mismatched=%0d expected 0", bad); end
      end
      left = 0;
      for (int w = 0; w < 2; w++) for (int s = 0; s < 16; s++) left += int'(m_dirty[w][s]);
      checks++; if (left !== 0 || bus.lines_written_o !== 6'd32) begin
         errors++; $display("FAIL alldirty_result dirty_left=%0d cnt=%0d expected 0/32", left, bus.lines_written_o); end
      checks++; if (r_done_cyc !== 34 + r_sum || r_err !== 0) begin
         errors++; $display("FAIL alldirty_latency got=%0d expected %0d stab=%0d", r_done_cyc, 34 + r_sum, r_err); end
   endtask

   task automatic test_random();
      int bad, n;
      for (int it = 0; it < 4; it++) begin
         fill(2);
         snapshot_expect();
         run_flush(0, 1'b0, 1'b0, 0);
         n = exp_addr.size();
         bad = 0;
         checks++; if (obs_addr.size() !== n) begin
            errors++; $display("FAIL rand%0d_writes got=%0d expected %0d", it, obs_addr.size(), n); end
         else begin
            for (int k = 0; k < n; k++) if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) bad++;
            checks++; if (bad !== 0) begin
               errors++; $display("FAIL rand%0d_payload mismatched=%0d expected 0", it, bad); end
         end
         bad = 0;
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
               if (m_dirty[w][s] !== (s_dirty[w][s] && !s_valid[w][s])) bad++;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
               if (m_valid[w][s] !== 1'b0) bad++;
`else
               if (m_valid[w][s] !== s_valid[w][s]) bad++;
`endif
            end
         checks++; if (bad !== 0) begin
            errors++; $display("FAIL rand%0d_sram_bits wrong=%0d expected 0", it, bad); end
         checks++; if (bus.lines_written_o !== 6'(n) || r_done_cyc !== 34 + r_sum || r_err !== 0 || r_busy_err !== 0) begin
            errors++; $display("FAIL rand%0d_summary cnt=%0d exp=%0d done=%0d exp=%0d stab=%0d busy=%0d",
                               it, bus.lines_written_o, n, r_done_cyc, 34 + r_sum, r_err, r_busy_err); end
      end
   endtask

   task automatic test_reset_in_wb();
      fill(1);
      snapshot_expect();
      run_flush(5, 1'b0, 1'b0, 2);
      checks++; if (r_abort_w !== 0 || r_abort_i !== 1) begin
         errors++; $display("FAIL abort_reached way=%0d set=%0d expected 0/1", r_abort_w, r_abort_i); end
      checks++; if (r_en_rst !== 1'b0 || r_busy_rst !== 1'b0 || r_cnt_rst !== 6'd0) begin
         errors++; $display("FAIL abort_outputs en=%b busy=%b cnt=%0d expected 0/0/0", r_en_rst, r_busy_rst, r_cnt_rst); end
      checks++; if (m_dirty[0][1] !== 1'b1 || m_dirty[0][0] !== 1'b0) begin
         errors++; $display("FAIL abort_dirty line2=%b expected 1 line1=%b expected 0", m_dirty[0][1], m_dirty[0][0]); end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (bus.flush_busy_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
         errors++; $display("FAIL abort_idle busy=%b en=%b expected 0/0", bus.flush_busy_o, bus.mem_enable_o); end
   endtask

   task automatic test_back_to_back();
      fill(2);
      snapshot_expect();
      run_flush(0, 1'b1, 1'b1, 0);
      checks++; if (r_pulses !== 1 || r_timeout) begin
         errors++; $display("FAIL held_req_pulses got=%0d expected 1 timeout=%0b", r_pulses, r_timeout); end
      checks++; if (obs_addr.size() !== exp_addr.size() || r_done_cyc !== 34 + r_sum) begin
         errors++; $display("FAIL held_req_flow writes=%0d exp=%0d done=%0d exp=%0d",
                            obs_addr.size(), exp_addr.size(), r_done_cyc, 34 + r_sum); end
      checks++; if (r_busy_err !== 0 || r_err !== 0 || bus.lines_written_o !== 6'(exp_addr.size())) begin
         errors++; $display("FAIL held_req_state busy=%0d stab=%0d cnt=%0d exp=%0d",
                            r_busy_err, r_err, bus.lines_written_o, exp_addr.size()); end
   endtask

   initial begin
      bus.flush_req_i = 1'b0;
      bus.mem_ack_i   = 1'b0;
      fill(0);
      test_reset();
      test_all_clean();
      test_single_dirty();
      test_all_dirty();
      test_random();
      test_reset_in_wb();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
